// File: rtl/agex_mul_sequencer_if.sv
// rtl/agex_mul_sequencer_if.sv - request/flush/stall/result bundle between AGEX and the multiply sequencer
interface agex_mul_sequencer_if #(
  parameter int DBITS    = 32,
  parameter int TAG_BITS = 32
);
  logic                req_valid;
  logic [DBITS-1:0]    req_a;
  logic [DBITS-1:0]    req_b;
  logic [TAG_BITS-1:0] req_tag;
  logic                flush;
  logic                stall;
  logic                busy;
  logic                done_valid;
  logic [DBITS-1:0]    done_result;
  logic [TAG_BITS-1:0] done_tag;

  modport master (
    output req_valid, req_a, req_b, req_tag, flush,
    input  stall, busy, done_valid, done_result, done_tag
  );

  modport slave (
    input  req_valid, req_a, req_b, req_tag, flush,
    output stall, busy, done_valid, done_result, done_tag
  );
endinterface

// File: rtl/agex_mul_sequencer.sv
// rtl/agex_mul_sequencer.sv - iterative shift-add MUL sequencer for AGEX; optional AGEX_MUL_EARLY_EXIT_EN
module agex_mul_sequencer #(
  parameter int DBITS     = 32,
  parameter int STEP_BITS = 1,
  parameter int TAG_BITS  = 32
) (
  input logic                 clk,
  input logic                 reset,
  agex_mul_sequencer_if.slave bus
);
  localparam int STEPS = DBITS / STEP_BITS;
  localparam int CNT_W = $clog2(STEPS + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state;
  logic [DBITS-1:0]    acc;
  logic [DBITS-1:0]    a_sh;
  logic [DBITS-1:0]    b_sh;
  logic [CNT_W-1:0]    count;
  logic [TAG_BITS-1:0] tag_q;
  logic [TAG_BITS-1:0] done_tag_q;
  logic [DBITS-1:0]    done_result_q;
  logic                done_q;
  logic                busy_q;

  logic [DBITS-1:0]    partial;
  logic [DBITS-1:0]    acc_next;
  logic [DBITS-1:0]    b_next;
  logic                last_step;
  logic                accept;

  // Partial product of the multiplicand with the low STEP_BITS of the multiplier.
  always_comb begin
    partial = '0;
    for (int i = 0; i < STEP_BITS; i++) begin
      if (b_sh[i]) begin
        partial = partial + (a_sh << i);
      end
    end
    acc_next = acc + partial;
    b_next   = b_sh >> STEP_BITS;
  end

`ifdef AGEX_MUL_EARLY_EXIT_EN
  // Once the remaining multiplier bits are all zero the accumulator is final.
  assign last_step = (count == CNT_W'(STEPS - 1)) || (b_next == '0);
`else
  assign last_step = (count == CNT_W'(STEPS - 1));
`endif

  assign accept = bus.req_valid && !bus.flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      acc           <= '0;
      a_sh          <= '0;
      b_sh          <= '0;
      count         <= '0;
      tag_q         <= '0;
      done_tag_q    <= '0;
      done_result_q <= '0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (accept) begin
            a_sh   <= bus.req_a;
            b_sh   <= bus.req_b;
            tag_q  <= bus.req_tag;
            acc    <= '0;
            count  <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          if (bus.flush) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            acc   <= acc_next;
            a_sh  <= a_sh << STEP_BITS;
            b_sh  <= b_next;
            count <= count + CNT_W'(1);
            if (last_step) begin
              done_q        <= 1'b1;
              done_result_q <= acc_next;
              done_tag_q    <= tag_q;
              state         <= DONE;
            end
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  // A flush seen during DONE kills the result before the AGEX latch takes it.
  assign bus.done_valid  = done_q && !bus.flush;
  assign bus.done_result = done_result_q;
  assign bus.done_tag    = done_tag_q;
  assign bus.busy        = busy_q;
  assign bus.stall       = (state == IDLE && accept) || (state == RUN);
endmodule
